// File: rtl/vdma_burst_arbiter.sv
// rtl/vdma_burst_arbiter.sv - round-robin arbiter sharing one AXI burst engine among VDMA channels
// Optional feature macro: VDMA_ARB_TAIL_PRIORITY_EN (tail requests win over burst requests)
module vdma_burst_arbiter #(
    parameter int ID_W  = 2,
    parameter int LSIZE = 9
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [(1<<ID_W)-1:0]           burst_req,
    input  logic [(1<<ID_W)-1:0]           tail_req,
    input  logic [(1<<ID_W)*LSIZE-1:0]     req_len,
    output logic [(1<<ID_W)-1:0]           resp,
    output logic [(1<<ID_W)-1:0]           done,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [LSIZE-1:0]               cmd_len,
    output logic [ID_W-1:0]                cmd_id,
    output logic                           cmd_tail,
    input  logic                           eng_done,
    output logic                           busy
);

    localparam int NUM_REQ = 1 << ID_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      ptr_nxt;

    // Arbitration results, only consumed while IDLE
    logic [NUM_REQ-1:0]   elig;
    logic                 arb_found;
    logic [ID_W-1:0]      arb_win;
    logic [ID_W-1:0]      cand;

    // Next values for the registered outputs
    logic                 cmd_valid_nxt;
    logic [LSIZE-1:0]     cmd_len_nxt;
    logic [ID_W-1:0]      cmd_id_nxt;
    logic                 cmd_tail_nxt;
    logic [NUM_REQ-1:0]   resp_nxt;
    logic [NUM_REQ-1:0]   done_nxt;
    logic                 busy_nxt;

    // Pick the first eligible channel at or after ptr, wrapping around
    always_comb begin
`ifdef VDMA_ARB_TAIL_PRIORITY_EN
        // Tail requests drain partially filled FIFOs, so they pre-empt full bursts;
        // a channel raising both is already counted in the tail set.
        elig = (|tail_req) ? tail_req : burst_req;
`else
        elig = burst_req | tail_req;
`endif
        arb_found = 1'b0;
        arb_win   = ptr;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ID_W-bit addition wraps naturally at NUM_REQ
            cand = ptr + ID_W'(k);
            if (!arb_found && elig[cand]) begin
                arb_found = 1'b1;
                arb_win   = cand;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cmd_valid_nxt = 1'b0;
        cmd_len_nxt   = cmd_len;
        cmd_id_nxt    = cmd_id;
        cmd_tail_nxt  = cmd_tail;
        resp_nxt      = '0;
        done_nxt      = '0;
        case (state)
            IDLE: begin
                if (enable && arb_found) begin
                    state_nxt     = ISSUE;
                    cmd_valid_nxt = 1'b1;
                    cmd_id_nxt    = arb_win;
                    cmd_len_nxt   = req_len[int'(arb_win)*LSIZE +: LSIZE];
                    // Both request bits set on one channel means a tail transfer
                    cmd_tail_nxt  = tail_req[arb_win];
                    ptr_nxt       = arb_win + ID_W'(1);
                end
            end
            ISSUE: begin
                // The command stays posted even if the requester drops its level
                cmd_valid_nxt = 1'b1;
                if (cmd_ready) begin
                    cmd_valid_nxt = 1'b0;
                    resp_nxt      = NUM_REQ'(1) << cmd_id;
                    state_nxt     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (eng_done) begin
                    done_nxt  = NUM_REQ'(1) << cmd_id;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // One dead cycle lets the channel retire its registered request
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, pointer and output registers
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cmd_valid <= 1'b0;
            cmd_len   <= '0;
            cmd_id    <= '0;
            cmd_tail  <= 1'b0;
            resp      <= '0;
            done      <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd_len   <= cmd_len_nxt;
            cmd_id    <= cmd_id_nxt;
            cmd_tail  <= cmd_tail_nxt;
            resp      <= resp_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vdma_burst_arbiter.sv
// tb/tb_vdma_burst_arbiter.sv - randomized self-checking bench for vdma_burst_arbiter
module tb_vdma_burst_arbiter;

    localparam int ID_W    = 2;
    localparam int LSIZE   = 9;
    localparam int NUM_REQ = 4;

    logic                       clock = 1'b0;
    logic                       rst;
    logic                       enable;
    logic [NUM_REQ-1:0]         burst_req;
    logic [NUM_REQ-1:0]         tail_req;
    logic [NUM_REQ*LSIZE-1:0]   req_len;
    logic [NUM_REQ-1:0]         resp;
    logic [NUM_REQ-1:0]         done;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [LSIZE-1:0]           cmd_len;
    logic [ID_W-1:0]            cmd_id;
    logic                       cmd_tail;
    logic                       eng_done;
    logic                       busy;

    vdma_burst_arbiter #(.ID_W(ID_W), .LSIZE(LSIZE)) dut (
        .clock     (clock),
        .rst       (rst),
        .enable    (enable),
        .burst_req (burst_req),
        .tail_req  (tail_req),
        .req_len   (req_len),
        .resp      (resp),
        .done      (done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_id    (cmd_id),
        .cmd_tail  (cmd_tail),
        .eng_done  (eng_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    int resp_pulses = 0;
    int done_pulses = 0;
    int valid_cycles = 0;

    bit               o_to;
    int               o_lat;
    int               o_id;
    int               o_len;
    bit               o_tl;
    bit               o_stable;
    logic [3:0]       o_resp;
    logic [3:0]       o_done;
    int               o_rcnt;
    int               o_dcnt;
    bit               o_busy;

    // Reference arbitration: first eligible channel scanning upward from p
    function automatic void model_pick(input logic [3:0] br, input logic [3:0] tr, input int p,
                                       output int win, output bit tl);
        logic [3:0] pool;
        pool = br | tr;
`ifdef VDMA_ARB_TAIL_PRIORITY_EN
        if (tr != 4'b0) pool = tr;
`endif
        win = -1;
        tl  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win < 0 && pool[(p + k) % NUM_REQ]) win = (p + k) % NUM_REQ;
        end
        if (win >= 0) tl = tr[win];
    endfunction

    function automatic int len_of(input int ch);
        return int'((req_len >> (ch * LSIZE)) & 36'h1ff);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        resp_pulses  += $countones(resp);
        done_pulses  += $countones(done);
        valid_cycles += int'(cmd_valid);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; burst_req = '0; tail_req = '0;
        cmd_ready = 1'b0; eng_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Plays the engine side of one transaction and reports what the DUT did
    task automatic run_txn(input int rdy_wait, input int done_wait, input bit drop_req, input bit drop_en);
        int r0, d0;
        r0 = resp_pulses; d0 = done_pulses;
        o_to = 1'b0; o_lat = 0; o_stable = 1'b1; o_resp = '0; o_done = '0;
        o_busy = 1'b1; o_id = -1; o_len = 0; o_tl = 1'b0;
        while (cmd_valid !== 1'b1 && o_lat < 20) begin
            tick();
            o_lat++;
        end
        if (cmd_valid !== 1'b1) begin
            o_to = 1'b1;
        end else begin
            o_id = int'(cmd_id); o_len = int'(cmd_len); o_tl = cmd_tail;
            if (drop_req) begin burst_req = '0; tail_req = '0; end
            repeat (rdy_wait) begin
                tick();
                if (cmd_valid !== 1'b1 || int'(cmd_len) != o_len || int'(cmd_id) != o_id || cmd_tail !== o_tl)
                    o_stable = 1'b0;
            end
            cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
            o_resp = resp;
            if (drop_en) enable = 1'b0;
            repeat (done_wait) tick();
            eng_done = 1'b1; tick(); eng_done = 1'b0;
            o_done = done;
            tick();
            o_busy = busy;
        end
        o_rcnt = resp_pulses - r0;
        o_dcnt = done_pulses - d0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_valid); end
        total++; if (cmd_len !== 9'd0) begin bad++; $display("FAIL reset_cmd_len got=%0d exp=0", cmd_len); end
        total++; if (cmd_id !== 2'd0) begin bad++; $display("FAIL reset_cmd_id got=%0d exp=0", cmd_id); end
        total++; if (cmd_tail !== 1'b0) begin bad++; $display("FAIL reset_cmd_tail got=%0b exp=0", cmd_tail); end
        total++; if (resp !== 4'b0 || done !== 4'b0) begin bad++; $display("FAIL reset_pulses resp=%b done=%b exp=0", resp, done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1;
        req_len = '0;
        req_len[8:0] = 9'd100;
        burst_req = 4'b0001;
        run_txn(0, 5, 0, 0);
        burst_req = '0;
        m_ptr = 1;
        total++;
        if (o_to) begin bad++; $display("FAIL single_timeout no cmd_valid"); end
        else begin
            total++; if (o_lat != 1) begin bad++; $display("FAIL single_latency got=%0d exp=1", o_lat); end
            total++; if (o_len != 100 || o_id != 0 || o_tl != 1'b0) begin
                bad++; $display("FAIL single_cmd len=%0d id=%0d tail=%0b exp 100/0/0", o_len, o_id, o_tl); end
            total++; if (o_resp !== 4'b0001) begin bad++; $display("FAIL single_resp got=%b exp=0001", o_resp); end
            total++; if (o_done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b exp=0001", o_done); end
            total++; if (o_rcnt != 1 || o_dcnt != 1) begin bad++; $display("FAIL single_pulse_count resp=%0d done=%0d exp 1/1", o_rcnt, o_dcnt); end
            total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_idle_after got busy=%0b exp=0", o_busy); end
        end
    endtask

    task automatic test_round_robin();
        int ew; bit et;
        do_reset();
        enable = 1'b1;
        req_len = {$urandom(), $urandom()};
        burst_req = 4'hf;
        for (int i = 0; i < 5; i++) begin
            model_pick(burst_req, tail_req, m_ptr, ew, et);
            run_txn(0, $urandom_range(0, 3), 0, 0);
            total++;
            if (o_to) begin bad++; $display("FAIL rr_timeout step=%0d", i); end
            else begin
                total++; if (o_id != ew || o_id != i % NUM_REQ) begin
                    bad++; $display("FAIL rr_order step=%0d got=%0d exp=%0d", i, o_id, i % NUM_REQ); end
                total++; if (o_len != len_of(ew)) begin bad++; $display("FAIL rr_len step=%0d got=%0d exp=%0d", i, o_len, len_of(ew)); end
                total++; if (o_resp !== 4'(1 << ew) || o_done !== 4'(1 << ew)) begin
                    bad++; $display("FAIL rr_pulses step=%0d resp=%b done=%b exp bit %0d", i, o_resp, o_done, ew); end
            end
            m_ptr = (ew + 1) % NUM_REQ;
        end
        burst_req = '0;
    endtask

    task automatic test_mixed_types();
        int exp_id; bit exp_tail;
        do_reset();
        enable = 1'b1;
        burst_req = 4'b0010;
        tail_req  = 4'b1000;
`ifdef VDMA_ARB_TAIL_PRIORITY_EN
        exp_id = 3; exp_tail = 1'b1;
`else
        exp_id = 1; exp_tail = 1'b0;
`endif
        run_txn(0, 1, 0, 0);
        burst_req = '0; tail_req = '0;
        m_ptr = (exp_id + 1) % NUM_REQ;
        total++;
        if (o_to) begin bad++; $display("FAIL mixed_timeout"); end
        else if (o_id != exp_id || o_tl != exp_tail) begin
            bad++; $display("FAIL mixed_winner id=%0d tail=%0b exp id=%0d tail=%0b", o_id, o_tl, exp_id, exp_tail);
        end
    endtask

    task automatic test_ready_stall();
        do_reset();
        enable = 1'b1;
        req_len[2*LSIZE +: LSIZE] = 9'h1a5;
        burst_req = 4'b0100;
        run_txn(10, 2, 1, 0);
        m_ptr = 3;
        total++;
        if (o_to) begin bad++; $display("FAIL stall_timeout"); end
        else begin
            total++; if (!o_stable) begin bad++; $display("FAIL stall_stable cmd fields changed while cmd_ready low"); end
            total++; if (o_id != 2 || o_len != 9'h1a5) begin bad++; $display("FAIL stall_cmd id=%0d len=%0d exp 2/421", o_id, o_len); end
            total++; if (o_resp !== 4'b0100 || o_rcnt != 1) begin
                bad++; $display("FAIL stall_resp got=%b count=%0d exp 0100 once", o_resp, o_rcnt); end
            total++; if (o_dcnt != 1) begin bad++; $display("FAIL stall_done_count got=%0d exp=1", o_dcnt); end
        end
    endtask

    task automatic test_reset_mid();
        int d0, ew; bit et;
        do_reset();
        enable = 1'b1;
        req_len[1*LSIZE +: LSIZE] = 9'h155;
        burst_req = 4'b0010;
        tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL rstmid_grant cmd_valid=%0b exp=1", cmd_valid); end
        burst_req = '0;
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        total++; if (resp !== 4'b0010) begin bad++; $display("FAIL rstmid_resp got=%b exp=0010", resp); end
        d0 = done_pulses;
        rst = 1'b1; tick(); rst = 1'b0;
        m_ptr = 0;
        total++; if (cmd_valid !== 1'b0 || cmd_len !== 9'd0 || cmd_id !== 2'd0 || cmd_tail !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs valid=%0b len=%0d id=%0d tail=%0b busy=%0b exp all 0",
                            cmd_valid, cmd_len, cmd_id, cmd_tail, busy); end
        eng_done = 1'b1; tick(); eng_done = 1'b0;
        tick();
        total++; if (done_pulses != d0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_done pulses=%0d busy=%0b exp 0/0", done_pulses - d0, busy); end
        burst_req = 4'b1010;
        model_pick(burst_req, tail_req, m_ptr, ew, et);
        run_txn(0, 0, 0, 0);
        burst_req = '0;
        m_ptr = (ew + 1) % NUM_REQ;
        total++;
        if (o_to) begin bad++; $display("FAIL rstmid_regrant_timeout"); end
        else if (o_id != ew) begin bad++; $display("FAIL rstmid_ptr_reset got=%0d exp=%0d", o_id, ew); end
    endtask

    task automatic test_enable_drop();
        int ew, v0; bit et;
        do_reset();
        enable = 1'b1;
        burst_req = 4'hf;
        model_pick(burst_req, tail_req, m_ptr, ew, et);
        run_txn(0, 3, 0, 1);
        m_ptr = (ew + 1) % NUM_REQ;
        total++;
        if (o_to) begin bad++; $display("FAIL endrop_timeout"); end
        else begin
            total++; if (o_id != ew || o_done !== 4'(1 << ew) || o_dcnt != 1) begin
                bad++; $display("FAIL endrop_done id=%0d done=%b count=%0d exp id %0d", o_id, o_done, o_dcnt, ew); end
        end
        v0 = valid_cycles;
        repeat (8) tick();
        total++; if (valid_cycles != v0 || busy !== 1'b0) begin
            bad++; $display("FAIL endrop_no_grant valid_cycles=%0d busy=%0b exp 0/0", valid_cycles - v0, busy); end
        enable = 1'b1;
        model_pick(burst_req, tail_req, m_ptr, ew, et);
        run_txn(0, 0, 0, 0);
        burst_req = '0;
        m_ptr = (ew + 1) % NUM_REQ;
        total++;
        if (o_to) begin bad++; $display("FAIL endrop_resume_timeout"); end
        else if (o_lat != 1 || o_id != ew) begin
            bad++; $display("FAIL endrop_resume lat=%0d id=%0d exp 1/%0d", o_lat, o_id, ew); end
    endtask

    task automatic test_random();
        int ew; bit et;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            burst_req = 4'($urandom_range(0, 15));
            tail_req  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
            if ((burst_req | tail_req) == 4'b0) burst_req = 4'(1 << $urandom_range(0, 3));
            req_len = {$urandom(), $urandom()};
            model_pick(burst_req, tail_req, m_ptr, ew, et);
            run_txn($urandom_range(0, 3), $urandom_range(0, 4), 0, 0);
            total++;
            if (o_to) begin bad++; $display("FAIL rand_timeout iter=%0d", i); end
            else if (o_lat != 1 || o_id != ew || o_len != len_of(ew) || o_tl != et ||
                     o_resp !== 4'(1 << ew) || o_done !== 4'(1 << ew)) begin
                bad++;
                $display("FAIL rand_txn iter=%0d lat=%0d id=%0d len=%0d tail=%0b resp=%b done=%b exp id=%0d len=%0d tail=%0b",
                         i, o_lat, o_id, o_len, o_tl, o_resp, o_done, ew, len_of(ew), et);
            end
            m_ptr = (ew + 1) % NUM_REQ;
        end
        burst_req = '0; tail_req = '0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; burst_req = '0; tail_req = '0; req_len = '0;
        cmd_ready = 1'b0; eng_done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_mixed_types();
        test_ready_stall();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/vdma_burst_arbiter.md
# vdma_burst_arbiter

Shares one AXI burst engine among `2**ID_W` FIFO status controllers (VDMA channels), each of which raises `burst_req` or `tail_req` with a `req_len`. The block picks one requester at a time using round-robin order and issues a single command to the engine. It returns the per-channel `resp` and `done` pulses that the controllers expect. It sits between the per-channel FIFO status controllers and the AXI master burst engine.

## Interface
Parameters:
- `ID_W`, 2: requester index width; `NUM_REQ = 2**ID_W`.
- `LSIZE`, 9: burst length width.

Ports:
- `clock`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new grants.
- `burst_req`  in  NUM_REQ  per-channel full-burst request (level).
- `tail_req`  in  NUM_REQ  per-channel tail request (level).
- `req_len`  in  NUM_REQ*LSIZE  per-channel length; channel i occupies bits [i*LSIZE +: LSIZE].
- `resp`  out  NUM_REQ  one-cycle pulse to the granted channel when the command is accepted.
- `done`  out  NUM_REQ  one-cycle pulse to the granted channel when the engine completes.
- `cmd_valid`  out  1  command valid to the engine.
- `cmd_ready`  in  1  engine accepts the command.
- `cmd_len`  out  LSIZE  latched length.
- `cmd_id`  out  ID_W  latched winner index.
- `cmd_tail`  out  1  set when the command is a tail transfer.
- `eng_done`  in  1  engine completion pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Channel i is requesting when `burst_req[i] | tail_req[i]`. When both are set on one channel, the channel is treated as a tail request and `cmd_tail=1`.
- Round-robin pointer `ptr`, width ID_W:
  - The search starts at `ptr` and runs ascending, wrapping at NUM_REQ-1 back to 0.
  - After each grant, `ptr` becomes winner+1 modulo NUM_REQ.
- State machine:
  - IDLE: if `enable` and any channel is requesting, latch winner, `cmd_len`, and `cmd_tail`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `cmd_valid=1`. On `cmd_valid & cmd_ready`, go to WAIT_DONE and pulse `resp[winner]` on the next cycle.
  - WAIT_DONE: on `eng_done`, pulse `done[winner]` on the next cycle and go to RELEASE.
  - RELEASE: one cycle, then IDLE. This gives the controller time to deassert its registered request.
- `cmd_len`, `cmd_id`, and `cmd_tail` are held stable from ISSUE entry through RELEASE.
- The requester dropping its request while in ISSUE does not withdraw the command; `cmd_valid` stays high until the handshake completes.
- `enable` falling mid-transaction: the current transaction completes normally, and no new grant is made.
- `eng_done` outside WAIT_DONE is ignored. `cmd_ready` outside ISSUE is ignored.
- Requesters other than the winner are not sampled until the FSM returns to IDLE.

## Timing
- Reset values: `cmd_valid=0`, `cmd_len=0`, `cmd_id=0`, `cmd_tail=0`, `resp=0`, `done=0`, `busy=0`, `ptr=0`, state IDLE.
- Reset asserted mid-transaction returns the block to IDLE on the next edge with all outputs at reset values. No `done` pulse is generated.
- Request sampled in IDLE at cycle N: `cmd_valid` is high at N+1.
- Handshake at cycle M: `resp` pulses at M+1.
- `eng_done` at cycle K: `done` pulses at K+1 and the FSM is in IDLE at K+2.
- Minimum spacing between grants is 4 cycles (IDLE, ISSUE, WAIT_DONE, RELEASE) when `cmd_ready` and `eng_done` respond immediately.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `VDMA_ARB_TAIL_PRIORITY_EN` defined:
  - Arbitration is two-level. If any channel asserts `tail_req`, round-robin runs over tail requesters only.
  - Otherwise round-robin runs over burst requesters.
  - `ptr` is shared between the two levels.
- Not defined: a single round-robin runs over all requesting channels regardless of type.

## Test plan
- Single channel 0, `burst_req=1`, `req_len=100`, `cmd_ready` tied high, `eng_done` 5 cycles after the handshake:
  - `cmd_valid` one cycle after the request.
  - `cmd_len=100`, `cmd_id=0`, `cmd_tail=0`.
  - `resp[0]` pulses one cycle after the handshake; `done[0]` pulses one cycle after `eng_done`.
- All 4 channels holding `burst_req` continuously: grants issue in the order 0,1,2,3,0, with `resp` and `done` pulses only on the matching bit.
- Channel 1 `burst_req`, channel 3 `tail_req`, `ptr=0`:
  - With the macro: channel 3 is granted first with `cmd_tail=1`.
  - Without the macro: channel 1 is granted first.
- `cmd_ready` held low for 10 cycles while the requester drops its request:
  - `cmd_valid` and `cmd_len` stay stable.
  - `resp` pulses exactly once after `cmd_ready` rises.
- `rst` asserted for one cycle during WAIT_DONE:
  - All outputs return to zero and no `done` pulse appears.
  - A later `eng_done` is ignored, and the next request is granted from `ptr=0`.
- `enable` dropped during WAIT_DONE with other requests pending: the current `done` is delivered and no new `cmd_valid` is raised until `enable` returns high.
